// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker: FSM state encoding,
// score-width helper and the width of one BCD digit.
package score_pkg;

    // Game phases: playing, final-score hold/flash, high-score display
    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        HOLD      = 2'd1,
        SHOW_HIGH = 2'd2
    } state_t;

    // Bits per BCD digit
    localparam int BCD_W = 4;

    // Bits needed to hold every score from 0 up to max_score inclusive
    function automatic int score_width(input int max_score);
        return (max_score < 1) ? 1 : $clog2(max_score + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter. A start pulse loads the binary value;
// one bit is shifted in per cycle with add-3 correction on every digit. After
// IN_W shift cycles the result is written to bcd and done pulses for one cycle.
// start must only be asserted while busy is low.
module bin_to_bcd_seq
    import score_pkg::*;
#(
    parameter int IN_W   = 6,
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IN_W-1:0]           bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd
);

    localparam int BCD_TOT = BCD_W * DIGITS;
    localparam int CNT_W   = $clog2(IN_W + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [IN_W-1:0]    shift_reg;
    logic [BCD_TOT-1:0] work_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic [BCD_TOT-1:0] bcd_reg;

    logic [BCD_TOT-1:0] adj;
    logic [BCD_TOT-1:0] step_val;

    // Add-3 correction on every digit that would overflow when doubled
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_adj
            logic [BCD_W-1:0] digit;
            assign digit = work_reg[gi*BCD_W +: BCD_W];
            assign adj[gi*BCD_W +: BCD_W] = (digit >= 4'd5) ? (digit + 4'd3) : digit;
        end
    endgenerate

    // Corrected digits shifted left with the next binary MSB entering at bit 0
    assign step_val = {adj[BCD_TOT-2:0], shift_reg[IN_W-1]};

    assign busy = (cnt_reg != '0);
    assign done = done_reg;
    assign bcd  = bcd_reg;

    // Load on start, then one shift-add-3 step per cycle until the count expires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            work_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            bcd_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg <= bin;
                work_reg  <= '0;
                cnt_reg   <= CNT_LOAD;
            end else if (busy) begin
                work_reg  <= step_val;
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    bcd_reg  <= step_val;
                    done_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/score_tracker_gen.sv
// Snake-game score tracker. Counts food pulses during play, ends the game on
// a bad collision or at MAX_SCORE, holds and flashes the final score for
// HOLD_CYCLES, then shows the high score until the next food pulse restarts
// play. The displayed value is converted to BCD by a sequential converter;
// changes arriving mid-conversion are coalesced so only the latest is shown.
module score_tracker_gen
    import score_pkg::*;
#(
    parameter int MAX_SCORE   = 50,
    parameter int SCORE_W     = score_width(MAX_SCORE),
    parameter int DIGITS      = 2,
    parameter int HOLD_CYCLES = 30_000_000,
    parameter int FLASH_HALF  = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      goodColl,
    input  logic                      badColl,
    output logic [SCORE_W-1:0]        dispScore,
    output logic [BCD_W*DIGITS-1:0]   bcdDigits,
    output logic                      bcdValid,
    output logic                      blank,
    output logic                      isGameComplete,
    output logic                      newHigh
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES);
    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);
    localparam logic [SCORE_W-1:0] MAX_VAL    = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);

    state_t              state_reg, state_next;
    logic [SCORE_W-1:0]  curr_reg, curr_next;
    logic [SCORE_W-1:0]  high_reg, high_next;
    logic [SCORE_W-1:0]  final_reg, final_next;
    logic [SCORE_W-1:0]  disp_reg, disp_next;
    logic                newhigh_reg, newhigh_next;
    logic                blank_reg, blank_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [FLASH_W-1:0]  flash_cnt_reg, flash_cnt_next;

    logic [SCORE_W-1:0]  score_inc;
    logic                end_game;
    logic [SCORE_W-1:0]  end_score;

    logic [BCD_W*DIGITS-1:0] bcd_reg;
    logic                    bcd_valid_reg;
    logic                    pending_reg;

    logic                    disp_change;
    logic                    conv_start;
    logic                    conv_busy;
    logic                    conv_done;
    logic [BCD_W*DIGITS-1:0] conv_bcd;

    // Game state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= PLAY;
            curr_reg      <= '0;
            high_reg      <= '0;
            final_reg     <= '0;
            disp_reg      <= '0;
            newhigh_reg   <= 1'b0;
            blank_reg     <= 1'b0;
            hold_cnt_reg  <= '0;
            flash_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            curr_reg      <= curr_next;
            high_reg      <= high_next;
            final_reg     <= final_next;
            disp_reg      <= disp_next;
            newhigh_reg   <= newhigh_next;
            blank_reg     <= blank_next;
            hold_cnt_reg  <= hold_cnt_next;
            flash_cnt_reg <= flash_cnt_next;
        end
    end

    // Next-state logic: scoring, game end, hold/flash timing and display select
    always_comb begin
        state_next     = state_reg;
        curr_next      = curr_reg;
        high_next      = high_reg;
        final_next     = final_reg;
        newhigh_next   = newhigh_reg;
        blank_next     = blank_reg;
        hold_cnt_next  = hold_cnt_reg;
        flash_cnt_next = flash_cnt_reg;
        score_inc      = curr_reg + ONE;
        end_game       = 1'b0;
        end_score      = curr_reg;
        disp_next      = '0;

        case (state_reg)
            PLAY: begin
                // A simultaneous food pulse still counts before the game ends
                if (goodColl) begin
                    curr_next = score_inc;
                    if (score_inc >= MAX_VAL) begin
                        end_game  = 1'b1;
                        end_score = score_inc;
                    end
                end
                if (badColl) begin
                    end_game  = 1'b1;
                    end_score = goodColl ? score_inc : curr_reg;
                end
            end
            HOLD: begin
                // Collisions are ignored; only the timers advance
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next     = SHOW_HIGH;
                    hold_cnt_next  = '0;
                    flash_cnt_next = '0;
                    blank_next     = 1'b0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                    if (flash_cnt_reg == FLASH_LAST) begin
                        flash_cnt_next = '0;
                        blank_next     = ~blank_reg;
                    end else begin
                        flash_cnt_next = flash_cnt_reg + 1'b1;
                    end
                end
            end
            SHOW_HIGH: begin
                // The restarting pulse is the first point of the new game
                if (goodColl) begin
                    state_next   = PLAY;
                    curr_next    = ONE;
                    newhigh_next = 1'b0;
                    if (ONE >= MAX_VAL) begin
                        end_game  = 1'b1;
                        end_score = ONE;
                    end
                end
            end
            default: begin
                state_next = PLAY;
            end
        endcase

        // Game end: latch final score, update high score, start the hold phase
        if (end_game) begin
            state_next     = HOLD;
            final_next     = end_score;
            curr_next      = '0;
            hold_cnt_next  = '0;
            flash_cnt_next = '0;
            blank_next     = 1'b0;
            if (end_score > high_reg) begin
                high_next    = end_score;
                newhigh_next = 1'b1;
            end else begin
                newhigh_next = 1'b0;
            end
        end

        case (state_next)
            PLAY:      disp_next = curr_next;
            HOLD:      disp_next = final_next;
            SHOW_HIGH: disp_next = high_next;
            default:   disp_next = '0;
        endcase
    end

    // A display change starts a conversion when the converter is free; a
    // change while busy, or a finishing conversion that is already stale,
    // restarts it with the value being displayed from the next cycle on.
    assign disp_change = (disp_next != disp_reg);
    assign conv_start  = ~conv_busy & (disp_change | (conv_done & pending_reg));

    bin_to_bcd_seq #(
        .IN_W   (SCORE_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (disp_next),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // BCD output register, valid flag and stale-request tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_reg       <= '0;
            bcd_valid_reg <= 1'b1;
            pending_reg   <= 1'b0;
        end else begin
            if (conv_done && !pending_reg && !disp_change) begin
                bcd_reg       <= conv_bcd;
                bcd_valid_reg <= 1'b1;
            end
            if (disp_change) begin
                bcd_valid_reg <= 1'b0;
            end
            if (conv_start) begin
                pending_reg <= 1'b0;
            end else if (conv_busy && disp_change) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign dispScore      = disp_reg;
    assign bcdDigits      = bcd_reg;
    assign bcdValid       = bcd_valid_reg;
    assign blank          = blank_reg;
    assign isGameComplete = (state_reg != PLAY);
    assign newHigh        = newhigh_reg;

endmodule
